irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- External interrupt controller that drives the core's interrupt request input (`zd`) and takes the core's exception-entry acknowledge and ERET back.
- Synchronises and latches up to 7 interrupt sources plus one built-in compare timer.
- Presents a single prioritised request with a source ID, and holds further requests until the handler returns, so interrupts do not nest.
- The core programs mask, mode and timer registers through a small register port in the MEM stage.

Parameters:
- N_SRC, 6: number of external sources; legal range 1..7.
- TMR_W, 32: timer counter and compare width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- src, input, N_SRC: raw external interrupt lines, asynchronous to clk.
- we, input, 1: register write strobe.
- waddr, input, 2: register write address.
- wdata, input, 32: register write data.
- raddr, input, 2: register read address.
- rdata, output, 32: register read data, combinational from raddr.
- irq_req, output, 1: registered interrupt request to the core (`zd`).
- irq_id, output, 3: ID of the requested source; valid while irq_req=1.
- irq_ack, input, 1: one-cycle pulse from the core on exception entry.
- eret, input, 1: one-cycle pulse when the core retires ERET.
- in_service, output, 1: high while a handler is active.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: irq_req=0, irq_id=0, in_service=0.
  - MASK=0, MODE=0, PEND=0, TCMP=0, timer count=0, synchronisers=0, state=IDLE.
- Synchronisation: each src bit passes through 2 flops giving s2. Edge-mode sources also keep a third flop, s3.
- Pending-bit rules, external sources i < N_SRC:
  - Level mode (MODE[i]=0): PEND[i] = s2[i] every cycle. W1C has no effect.
  - Edge mode (MODE[i]=1): PEND[i] sets on s2 & ~s3. It clears on W1C to PEND, or on irq_ack with irq_id=i.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Timer:
  - Count increments every cycle and wraps at 2^TMR_W.
  - When TCMP != 0 and count == TCMP: PEND[N_SRC] sets and count resets to 0.
  - A write to TCMP resets count to 0 and clears PEND[N_SRC].
  - PEND[N_SRC] is also cleared by W1C bit N_SRC or by an ack of ID N_SRC.
  - The timer is always edge-like: mode is ignored.
- Eligibility: elig = PEND & {1'b1 timer-enable = MASK[N_SRC], MASK[N_SRC-1:0]}. Lowest index has highest priority.
- Register map (address, meaning, access):
  - 0: MASK[N_SRC:0], RW.
  - 1: MODE[N_SRC-1:0], RW.
  - 2: PEND, read; write-1-to-clear.
  - 3: TCMP, RW.
  - Unused read bits return 0. rdata has no side effects.
- State machine, state is one of IDLE, REQ, SERVICE:
  - IDLE: if elig != 0, next state is REQ and irq_id is latched to the priority-encoded index of elig.
  - REQ: irq_req=1 and irq_id is held stable, even if higher-priority bits arrive.
    - On irq_ack: next state is SERVICE; irq_req drops the next cycle; the edge/timer pending bit for irq_id is cleared.
    - Else if elig[irq_id]==0 (masked or cleared): back to IDLE with irq_req=0. A new selection happens no earlier than the next IDLE cycle.
  - SERVICE: irq_req=0, in_service=1.
    - On eret: IDLE.
    - Pending bits keep accumulating; they are re-arbitrated in IDLE, so there is a minimum one-cycle bubble between eret and the next irq_req.
  - irq_ack outside REQ and eret outside SERVICE are ignored.
- Latency: a src edge sampled at clock k gives s2 at k+1, PEND at k+2, state REQ at k+3, and irq_req high after the k+3 edge.
- Register writes take effect at the clock edge. A MASK write that makes elig nonzero in IDLE produces irq_req 2 edges later.
- A reset asserted mid-request or mid-service returns everything to reset values immediately; no pending state survives.

Decomposition:
- Shared package `irq_pkg`:
  - Register address constants: ADDR_MASK=0, ADDR_MODE=1, ADDR_PEND=2, ADDR_TCMP=3.
  - State encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - Constant ID_W=3.
- One natural sub-module, `irq_sync2`: a parameterised 2-flop synchroniser with asynchronous active-low reset, instantiated once with width N_SRC.
- Priority encoder, timer and FSM stay inline.

Test Plan:
- Level path: MASK=0x01, MODE=0; hold src[0]=1 → irq_req=1, irq_id=0 exactly 4 edges later. Then irq_ack → in_service=1, irq_req=0. Then eret → IDLE, and irq_req returns 2 edges later while src[0] is still high.
- Priority and hold:
  - MASK=0x3F, MODE=0x3F; pulse src[4], and 1 cycle later pulse src[1] → irq_id=4 stays held through REQ.
  - After ack of 4 and eret → irq_id=1; PEND read shows 0x02 before that second ack.
- Withdraw: edge src[2], MASK bit 2 set; while in REQ, W1C PEND=0x04 → irq_req falls, state IDLE, no ack needed, PEND reads 0.
- Timer: MASK=0x40 (bit N_SRC=6), TCMP=10 → irq_id=6 with irq_req rising 11–12 cycles after the write. Ack clears PEND[6], and the timer retriggers 11 cycles after the match.
- Collision and reset:
  - Edge set and W1C of the same bit in one cycle → bit stays set.
  - Assert rst_n=0 while in_service=1 → all outputs 0 asynchronously, before the next clk.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding and
// the priority encoder used to pick the lowest-numbered eligible source.
package irq_pkg;
    localparam int ID_W = 3;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_TCMP = 2'd3;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    typedef logic [ID_W-1:0] irq_id_t;

    // Lowest set index wins; returns 0 for an all-zero vector.
    function automatic irq_id_t prio_enc(input logic [7:0] vec);
        prio_enc = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) prio_enc = irq_id_t'(i);
        end
    endfunction
endpackage

// File: rtl/irq_ctrl_if.sv
// Core-side connection of the interrupt controller: MEM-stage register port
// plus the request / acknowledge / ERET handshake.
interface irq_ctrl_if;
    import irq_pkg::*;

    logic          we;
    logic [1:0]    waddr;
    logic [31:0]   wdata;
    logic [1:0]    raddr;
    logic [31:0]   rdata;
    logic          irq_req;
    irq_id_t       irq_id;
    logic          irq_ack;
    logic          eret;
    logic          in_service;

    modport master (
        output we, waddr, wdata, raddr, irq_ack, eret,
        input  rdata, irq_req, irq_id, in_service
    );

    modport slave (
        input  we, waddr, wdata, raddr, irq_ack, eret,
        output rdata, irq_req, irq_id, in_service
    );
endinterface

// File: rtl/irq_sync2.sv
// Two-flop synchroniser for asynchronous input lines.
module irq_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] ff1_q;
    logic [W-1:0] ff2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= '0;
            ff2_q <= '0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;
endmodule

// File: rtl/irq_ctrl.sv
// Non-nesting interrupt controller: latches external sources and a compare
// timer, presents one prioritised request and blocks further ones until ERET.
//   state   | meaning
//   IDLE    | arbitrate eligible pending bits
//   REQ     | irq_req high, irq_id frozen until ack or withdrawal
//   SERVICE | handler running, wait for eret
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int TMR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_i,
    irq_ctrl_if.slave        bus
);
    logic [N_SRC-1:0] s2;
    logic [N_SRC-1:0] s3_q;
    logic [N_SRC:0]   mask_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC:0]   pend_q, pend_d;
    logic [TMR_W-1:0] tcmp_q, cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    irq_id_t          id_q, id_d;
    logic [7:0]       elig;
    logic             ack_fire, w1c, tcmp_we, tmr_hit;

    irq_sync2 #(.W(N_SRC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (src_i),
        .q_o   (s2)
    );

    assign ack_fire = (state_q == REQ) && bus.irq_ack;
    assign w1c      = bus.we && (bus.waddr == ADDR_PEND);
    assign tcmp_we  = bus.we && (bus.waddr == ADDR_TCMP);
    assign tmr_hit  = (tcmp_q != '0) && (cnt_q == tcmp_q);
    assign cnt_d    = (tcmp_we || tmr_hit) ? '0 : cnt_q + TMR_W'(1);
    assign elig     = 8'(pend_q & mask_q);

    // Clears are applied first so a simultaneous set always wins.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (!mode_q[i]) begin
                pend_d[i] = s2[i];
            end else begin
                if ((w1c && bus.wdata[i]) || (ack_fire && id_q == irq_id_t'(i)))
                    pend_d[i] = 1'b0;
                if (s2[i] && !s3_q[i])
                    pend_d[i] = 1'b1;
            end
        end
        if ((w1c && bus.wdata[N_SRC]) || tcmp_we ||
            (ack_fire && id_q == irq_id_t'(N_SRC)))
            pend_d[N_SRC] = 1'b0;
        if (tmr_hit)
            pend_d[N_SRC] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    state_d = REQ;
                    id_d    = prio_enc(elig);
                end
            end
            REQ: begin
                if (bus.irq_ack)
                    state_d = SERVICE;
                else if (!elig[id_q])
                    state_d = IDLE;
            end
            SERVICE: begin
                if (bus.eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            mode_q  <= '0;
            tcmp_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            s3_q    <= '0;
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            if (bus.we && bus.waddr == ADDR_MASK) mask_q <= bus.wdata[N_SRC:0];
            if (bus.we && bus.waddr == ADDR_MODE) mode_q <= bus.wdata[N_SRC-1:0];
            if (tcmp_we) tcmp_q <= bus.wdata[TMR_W-1:0];
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            s3_q    <= s2;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.raddr)
            ADDR_MASK: bus.rdata = 32'(mask_q);
            ADDR_MODE: bus.rdata = 32'(mode_q);
            ADDR_PEND: bus.rdata = 32'(pend_q);
            ADDR_TCMP: bus.rdata = 32'(tcmp_q);
            default:   bus.rdata = '0;
        endcase
    end

    assign bus.irq_req    = (state_q == REQ);
    assign bus.irq_id     = id_q;
    assign bus.in_service = (state_q == SERVICE);
endmodule
